// File: rtl/fb_pkg.sv
// Shared constants, enums and helpers for the LCD framebuffer arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fb_pkg;

  localparam int              ADDR_W   = 11;
  localparam logic [7:0]      FB_WIDTH = 8'd240;
  localparam int              FB_PAGES = 8;
  localparam logic [ADDR_W-1:0] FB_BYTES = 11'd1920;
  localparam logic [ADDR_W-1:0] FB_LAST  = 11'd1919;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_LCD,
    GNT_WR,
    GNT_RD,
    GNT_CLR
  } gnt_t;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clr_state_t;

  // Who owns the RAM data returning two cycles after a grant.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_LCD,
    TAG_HOST
  } tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_entry_t;

  // page*240 + x without a multiplier: (page<<8) - (page<<4) + x.
  function automatic logic [ADDR_W-1:0] page_addr(input logic [2:0] page,
                                                   input logic [7:0] x);
    page_addr = {page, 8'd0} - {4'd0, page, 4'd0} + {3'd0, x};
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Generic synchronous FIFO with full/empty flags; pop_data shows the head entry.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
//   ports: clk, reset (sync, active-high); push/push_data; pop/pop_data; full, empty
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: LCD refresh > host write FIFO > host read > clear.
// Latency: read granted at t drives ram_addr at t; lcd_pixels / rd_data valid at t+2.
// Backpressure: wr_ready = FIFO not full; rd_ready only when LCD, FIFO and clear all idle.
//   ports: lcd_x/lcd_y -> lcd_pixels; wr_* host write stream; rd_* host random read;
//          clear_req/clear_value/busy whole-buffer fill; ram_* registered single-port RAM
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        lcd_x,
  input  logic [3:0]        lcd_y,
  output logic [7:0]        lcd_pixels,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [7:0]        rd_data,
  input  logic              clear_req,
  input  logic [7:0]        clear_value,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  logic [ADDR_W-1:0] lcd_addr, last_lcd_addr;
  logic              lcd_oor, lcd_pending, lcd_pending_n, lcd_req;
  logic [7:0]        lcd_pix_q;
  gnt_t              gnt;
  tag_t              tag_s1;
  logic              host_zero_s1;
  logic              wr_in_range, rd_in_range, wr_hit, clr_hit;

  clr_state_t        clr_state, clr_state_n;
  logic [ADDR_W-1:0] clr_addr, clr_addr_n;
  logic [7:0]        clr_val, clr_val_n;
  logic              clr_done;

  wr_entry_t         fifo_head, fifo_in;
  logic              fifo_full, fifo_empty, fifo_pop;

  assign fifo_in  = '{addr: wr_addr, data: wr_data};
  assign wr_ready = !reset && !fifo_full;
  assign fifo_pop = (gnt == GNT_WR);

  fb_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid && wr_ready),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign lcd_addr    = page_addr(lcd_y[2:0], lcd_x);
  assign lcd_oor     = (lcd_x >= FB_WIDTH);
  assign wr_in_range = (fifo_head.addr < FB_BYTES);
  assign rd_in_range = (rd_addr < FB_BYTES);

  // The address compare is folded in combinationally so a new LCD position wins
  // the very cycle it appears; lcd_pending covers stale-data refreshes.
  assign lcd_req  = !reset && !lcd_oor && (lcd_pending || (lcd_addr != last_lcd_addr));
  assign busy     = !reset && (clr_state == CLR_RUN);
  assign rd_ready = !reset && rd_valid && !lcd_req && fifo_empty && !busy;

  always_comb begin
    gnt = GNT_NONE;
    if (lcd_req)                   gnt = GNT_LCD;
    else if (!reset && !fifo_empty) gnt = GNT_WR;
    else if (rd_ready)             gnt = GNT_RD;
    else if (busy)                 gnt = GNT_CLR;
  end

  // Out-of-range host accesses take their grant slot but leave the RAM port idle.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (gnt)
      GNT_LCD: ram_addr = lcd_addr;
      GNT_WR: begin
        if (wr_in_range) begin
          ram_addr  = fifo_head.addr;
          ram_we    = 1'b1;
          ram_wdata = fifo_head.data;
        end
      end
      GNT_RD:  if (rd_in_range) ram_addr = rd_addr;
      GNT_CLR: begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_val;
      end
      default: ;
    endcase
  end

  // Any write landing on the byte the panel is showing forces a re-read.
  assign wr_hit  = (gnt == GNT_WR) && wr_in_range && (fifo_head.addr == last_lcd_addr);
  assign clr_hit = (gnt == GNT_CLR) && (clr_addr == last_lcd_addr);
  assign lcd_pending_n = ((lcd_pending || (lcd_addr != last_lcd_addr)) && (gnt != GNT_LCD))
                         || wr_hit || clr_hit || clr_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_lcd_addr <= '0;
      lcd_pending   <= 1'b1;
      tag_s1        <= TAG_NONE;
      host_zero_s1  <= 1'b0;
      lcd_pix_q     <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      last_lcd_addr <= lcd_addr;
      lcd_pending   <= lcd_pending_n;
      case (gnt)
        GNT_LCD: tag_s1 <= TAG_LCD;
        GNT_RD:  tag_s1 <= TAG_HOST;
        default: tag_s1 <= TAG_NONE;
      endcase
      host_zero_s1  <= !rd_in_range;
      rd_data_valid <= (tag_s1 == TAG_HOST);
      if (tag_s1 == TAG_LCD)  lcd_pix_q <= ram_rdata;
      if (tag_s1 == TAG_HOST) rd_data   <= host_zero_s1 ? 8'd0 : ram_rdata;
    end
  end

  assign lcd_pixels = lcd_oor ? 8'd0 : lcd_pix_q;

  // Clear sequencer. A FIFO write landing mid-clear ahead of clr_addr is later
  // overwritten by the fill; host traffic order relative to a clear is not preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_val   <= '0;
    end else begin
      clr_state <= clr_state_n;
      clr_addr  <= clr_addr_n;
      clr_val   <= clr_val_n;
    end
  end

  always_comb begin
    clr_state_n = clr_state;
    clr_addr_n  = clr_addr;
    clr_val_n   = clr_val;
    clr_done    = 1'b0;
    case (clr_state)
      CLR_IDLE: begin
        if (clear_req) begin
          clr_val_n   = clear_value;
          clr_addr_n  = '0;
          clr_state_n = CLR_RUN;
        end
      end
      CLR_RUN: begin
        if (gnt == GNT_CLR) begin
          clr_addr_n = clr_addr + 11'd1;
          if (clr_addr == FB_LAST) clr_state_n = CLR_DONE;
        end
      end
      CLR_DONE: begin
        clr_done    = 1'b1;
        clr_state_n = CLR_IDLE;
      end
      default: clr_state_n = CLR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lcd_x;
  logic [3:0]  lcd_y;
  logic [7:0]  lcd_pixels;
  logic        wr_valid, wr_ready;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [10:0] rd_addr;
  logic        rd_data_valid;
  logic [7:0]  rd_data;
  logic        clear_req;
  logic [7:0]  clear_value;
  logic        busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mem [2048];

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk(clk), .reset(reset),
    .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_pixels(lcd_pixels),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .clear_req(clear_req), .clear_value(clear_value), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Registered single-port RAM; a few preset bytes are loaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem[0]   <= 8'h5A;
      mem[100] <= 8'h96;
      mem[245] <= 8'h11;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rd_data_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rd_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {31'd0, rd_data_valid}, 32'd0);
      end else begin
        chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic host_read(input logic [10:0] a, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("rd_ready_timeout", {31'd0, got}, 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  logic [10:0] wa [5];
  logic [7:0]  wd [5];
  logic [7:0]  exp_rdy;
  logic        got_rdy;
  int          idx;
  int          nbusy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wa[0] = 11'd300; wd[0] = 8'hA0;
    wa[1] = 11'd301; wd[1] = 8'hA1;
    wa[2] = 11'd302; wd[2] = 8'hA2;
    wa[3] = 11'd300; wd[3] = 8'hA3;
    wa[4] = 11'd303; wd[4] = 8'hA4;
    exp_rdy = 8'b1000_1111;

    reset = 1'b1; lcd_x = 8'd0; lcd_y = 4'd0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b1; rd_addr = '0;
    clear_req = 1'b0; clear_value = '0;
    repeat (3) tick();
    chk("rst_lcd_pixels", {24'd0, lcd_pixels}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_rd_data_valid", {31'd0, rd_data_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
    rd_valid = 1'b0;
    reset = 1'b0;

    // Initial forced refresh read of (0,0).
    @(negedge clk);
    chk("init_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("init_lcd_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    chk("init_pix_cycle2", {24'd0, lcd_pixels}, 32'd0);
    tick();
    chk("init_pix_cycle3", {24'd0, lcd_pixels}, 32'h5A);

    // Host write to the byte the panel is showing triggers a re-read.
    lcd_x = 8'd5; lcd_y = 4'd1;
    repeat (4) tick();
    chk("pix_245_before", {24'd0, lcd_pixels}, 32'h11);
    wr_valid = 1'b1; wr_addr = 11'd245; wr_data = 8'hC3;
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr245_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr245_ram_addr", {21'd0, ram_addr}, 32'd245);
    chk("wr245_ram_wdata", {24'd0, ram_wdata}, 32'hC3);
    repeat (4) tick();
    chk("pix_245_after", {24'd0, lcd_pixels}, 32'hC3);

    // Burst of 5 writes while LCD moves every cycle, starving FIFO pops.
    lcd_y = 4'd0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) lcd_x = 8'(10 + k);
      wr_valid = (idx < 5);
      if (idx < 5) begin
        wr_addr = wa[idx];
        wr_data = wd[idx];
      end
      @(negedge clk);
      chk($sformatf("burst_wr_ready_k%0d", k), {31'd0, wr_ready}, {31'd0, exp_rdy[k]});
      got_rdy = wr_ready;
      @(posedge clk);
      #1;
      if (got_rdy && wr_valid) idx++;
    end
    wr_valid = 1'b0;
    chk("burst_accepted", idx, 32'd5);
    repeat (8) tick();
    host_read(11'd300, 8'hA3);
    host_read(11'd301, 8'hA1);
    host_read(11'd302, 8'hA2);
    host_read(11'd303, 8'hA4);
    host_read(11'd245, 8'hC3);
    repeat (4) tick();

    // Host read colliding with an LCD move: LCD goes first.
    lcd_x = 8'd20; rd_valid = 1'b1; rd_addr = 11'd100;
    @(negedge clk);
    chk("collide_rd_ready0", {31'd0, rd_ready}, 32'd0);
    chk("collide_lcd_addr", {21'd0, ram_addr}, 32'd20);
    tick();
    @(negedge clk);
    chk("collide_rd_ready1", {31'd0, rd_ready}, 32'd1);
    chk("collide_rd_addr", {21'd0, ram_addr}, 32'd100);
    exp_q.push_back(8'h96);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("collide_rdv_t1", {31'd0, rd_data_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("collide_rdv_t2", {31'd0, rd_data_valid}, 32'd1);
    tick();

    // Out-of-range host read returns 0 without touching the RAM.
    rd_valid = 1'b1; rd_addr = 11'd2000;
    @(negedge clk);
    chk("oor_rd_ready", {31'd0, rd_ready}, 32'd1);
    chk("oor_ram_we", {31'd0, ram_we}, 32'd0);
    chk("oor_ram_addr", {21'd0, ram_addr}, 32'd0);
    exp_q.push_back(8'h00);
    tick();
    rd_valid = 1'b0;
    repeat (4) tick();

    // Full clear to 0xFF with an ignored second request and a blocked host read.
    clear_value = 8'hFF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0; clear_value = 8'h00;
    chk("clear_busy_start", {31'd0, busy}, 32'd1);
    nbusy = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 100) begin rd_valid = 1'b1; rd_addr = 11'd5; end
      if (c == 500) clear_req = 1'b1;
      @(negedge clk);
      if (c == 100) chk("rd_blocked_busy", {31'd0, rd_ready}, 32'd0);
      if (!busy) break;
      nbusy++;
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      clear_req = 1'b0;
    end
    rd_valid = 1'b0; clear_req = 1'b0;
    chk("clear_busy_min", {31'd0, nbusy >= 1920}, 32'd1);
    chk("clear_busy_max", {31'd0, nbusy <= 1925}, 32'd1);
    repeat (6) tick();
    chk("clear_lcd_pix", {24'd0, lcd_pixels}, 32'hFF);
    for (int a = 0; a < 1920; a++) host_read(11'(a), 8'hFF);
    repeat (4) tick();

    // Reset in the middle of a clear.
    clear_value = 8'h00; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (1000) tick();
    chk("mid_clear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_busy_now", {31'd0, busy}, 32'd0);
    tick();
    chk("reset_busy_edge", {31'd0, busy}, 32'd0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("after_reset_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    host_read(11'd10, 8'h00);
    host_read(11'd1500, 8'hFF);
    repeat (6) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single-port framebuffer RAM (240 x 8 pages = 1920 bytes) behind the LCD panel driver.
- Shares the RAM between three requesters:
  - the LCD refresh reader, which presents x/y and expects a pixel byte back;
  - a host write stream, buffered in a small FIFO;
  - a host random-read port.
- Also sequences a whole-buffer clear.
- Sits between the LCD driver and host-side logic (serial/terminal renderer).

Parameters:
- FB_WIDTH, 240, columns per page row.
- FB_PAGES, 8, 8-pixel page rows; only lcd_y[2:0] is used.
- ADDR_W, 11, RAM address width.
- WR_FIFO_DEPTH, 4, host write FIFO entries (power of two).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lcd_x  in  8  LCD column request
- lcd_y  in  4  LCD page request; bit 3 ignored
- lcd_pixels  out  8  byte at the current (lcd_x, lcd_y)
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO not full
- wr_addr  in  ADDR_W  write address
- wr_data  in  8  write byte
- rd_valid  in  1  host read request
- rd_ready  out  1  host read granted this cycle
- rd_addr  in  ADDR_W  read address
- rd_data_valid  out  1  one-cycle pulse
- rd_data  out  8  read result
- clear_req  in  1  start clear (pulse)
- clear_value  in  8  fill byte, sampled at clear start
- busy  out  1  clear in progress
- ram_addr  out  ADDR_W
- ram_we  out  1
- ram_wdata  out  8
- ram_rdata  in  8  registered RAM; valid the cycle after address issue

Behaviour:
- Reset values: lcd_pixels=0, wr_ready=0 for the reset cycle then 1, rd_ready=0, rd_data_valid=0, rd_data=0, busy=0, ram_we=0, ram_addr=0, ram_wdata=0. FIFO is emptied. lcd_pending=1, forcing an initial refresh read.
- LCD address: lcd_addr = lcd_y[2:0]*240 + lcd_x, computed as (row<<8)-(row<<4)+x in 11 bits.
  - lcd_x >= 240 gives out-of-range: lcd_pixels is forced to 0 and no RAM read is issued.
- lcd_pending is set when any of the following holds:
  - lcd_addr differs from last_lcd_addr;
  - a granted host write or clear write hits last_lcd_addr;
  - a clear has just completed.
- lcd_pending clears when the LCD read is granted.
- Grant, one per cycle, fixed priority: LCD read > host write (FIFO non-empty) > host read > clear step.
  - LCD and host-write accesses are still granted while busy.
  - Host reads are blocked while busy.
- rd_ready is combinational: asserted when rd_valid=1, no LCD grant, FIFO empty, and not busy. The transfer happens when rd_valid && rd_ready.
- Read latency:
  - Grant at cycle t drives ram_addr at t.
  - ram_rdata is captured at the end of t+1.
  - lcd_pixels, or rd_data with rd_data_valid=1, is visible at t+2.
  - A 2-stage tag pipeline (NONE/LCD/HOST) routes the data.
- Host read with rd_addr >= 1920: accepted, no RAM access, rd_data=0 with the same latency.
- LCD guarantee: if lcd_x/lcd_y are stable for 4 cycles, lcd_pixels is correct. The worst case is an LCD grant one cycle late behind nothing, since LCD has top priority.
- Write FIFO:
  - Push on wr_valid && wr_ready; wr_ready = !full.
  - No bypass: when full, wr_ready stays 0 even in a pop cycle.
  - Pop on host-write grant.
  - Entries with wr_addr >= 1920 are popped and dropped, with ram_we=0.
- Clear FSM states:
  - IDLE: on clear_req, latch clear_value, set clr_addr=0 and busy=1, then go to CLEAR.
  - CLEAR: on each clear grant, write clr_addr and increment it. After writing 1919, go to DONE.
  - DONE: set lcd_pending, busy=0, then go to IDLE.
- clear_req while busy is ignored. A FIFO write that lands during a clear may be overwritten by the clear if clr_addr has not yet passed its address; this ordering is accepted and documented.
- Reset mid-clear or mid-read: everything returns to reset values and in-flight read tags are dropped, so no rd_data_valid pulse appears.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH, FB_PAGES, FB_BYTES=1920, ADDR_W;
  - grant enum GNT_NONE/GNT_LCD/GNT_WR/GNT_RD/GNT_CLR;
  - clear state enum CLR_IDLE/CLR_RUN/CLR_DONE;
  - a function computing page*240+x.
- One sub-module, fb_wr_fifo: synchronous FIFO with full/empty flags, parameterised depth and width (ADDR_W+8).

Test Plan:
- After reset, with lcd_x=0 and lcd_y=0 and RAM[0]=0x5A: LCD read issues at cycle 1 (first cycle after reset deasserts); lcd_pixels=0x5A by cycle 3.
- Host writes addr 245=0xC3 while lcd_x=5, lcd_y=1 → RAM write, then automatic LCD re-read; lcd_pixels=0xC3 within 4 cycles.
- Push 5 writes back-to-back with no stalls → wr_ready drops after 4 accepted; all 5 land in RAM in order, with the 5th accepted after the first pop.
- Host read of addr 100 at the same cycle as an lcd_x change → LCD granted first, rd_ready=0 that cycle; host read is accepted next cycle and rd_data_valid pulses 2 cycles later.
- Host read of addr 2000 → rd_data_valid with rd_data=0 and no ram access.
- clear_req with clear_value=0xFF → busy for ≥1920 cycles and all addresses read back 0xFF. A second clear_req mid-clear is ignored. Reset at clr_addr=1000 drops busy immediately.
